// File: rtl/seq_regfile.sv
// ---------------------------------------------------------------------------
// seq_regfile
//   Y86-64 decode and write-back register file for the SEQ datapath.
//   The icode, rA and rB fields are decoded combinationally into the source
//   IDs (srcA/srcB) and destination IDs (dstE/dstM). The fifteen 64-bit
//   program registers are read combinationally. valE and valM are written
//   back on the rising clock edge. Register ID 4'hF (RNONE) is the null
//   register: it reads as zero and swallows writes.
//
// Parameters
//   N         register/data width (64)
//   RSP_INIT  reset value of %rsp (ID 4)
//
// Ports
//   clk          in   system clock, rising edge
//   async_reset  in   asynchronous active-low reset
//   wr_en        in   write-back enable (0 = stall/halt, no writes)
//   icode        in   instruction code
//   rA, rB       in   register specifier fields
//   cnd          in   condition from execute, gates the cmovXX write
//   valE, valM   in   write-back data for dstE / dstM
//   dbg_sel      in   debug read select
//   valA, valB   out  read data for srcA / srcB
//   srcA, srcB   out  decoded source IDs
//   dstE, dstM   out  decoded destination IDs
//   dbg_val      out  contents of register dbg_sel
// ---------------------------------------------------------------------------
module seq_regfile #(
  parameter int unsigned   N        = 64,
  parameter logic [N-1:0]  RSP_INIT = '0
) (
  input  logic         clk,
  input  logic         async_reset,
  input  logic         wr_en,
  input  logic [3:0]   icode,
  input  logic [3:0]   rA,
  input  logic [3:0]   rB,
  input  logic         cnd,
  input  logic [N-1:0] valE,
  input  logic [N-1:0] valM,
  input  logic [3:0]   dbg_sel,
  output logic [N-1:0] valA,
  output logic [N-1:0] valB,
  output logic [3:0]   srcA,
  output logic [3:0]   srcB,
  output logic [3:0]   dstE,
  output logic [3:0]   dstM,
  output logic [N-1:0] dbg_val
);

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'h4;

  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam int unsigned NUM_REGS = 15;

  logic [N-1:0] r_regs [0:NUM_REGS-1];

  logic [3:0] w_src_a;
  logic [3:0] w_src_b;
  logic [3:0] w_dst_e;
  logic [3:0] w_dst_m;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_src_a = RNONE;
    w_src_b = RNONE;
    w_dst_e = RNONE;
    w_dst_m = RNONE;
    case (icode)
      I_CMOVXX: begin
        w_src_a = rA;
        // A failed condition turns the move into a no-op.
        w_dst_e = cnd ? rB : RNONE;
      end
      I_IRMOVQ: begin
        w_dst_e = rB;
      end
      I_RMMOVQ: begin
        w_src_a = rA;
        w_src_b = rB;
      end
      I_MRMOVQ: begin
        w_src_b = rB;
        w_dst_m = rA;
      end
      I_OPQ: begin
        w_src_a = rA;
        w_src_b = rB;
        w_dst_e = rB;
      end
      I_CALL: begin
        w_src_b = RSP;
        w_dst_e = RSP;
      end
      I_RET: begin
        w_src_a = RSP;
        w_src_b = RSP;
        w_dst_e = RSP;
      end
      I_PUSHQ: begin
        w_src_a = rA;
        w_src_b = RSP;
        w_dst_e = RSP;
      end
      I_POPQ: begin
        w_src_a = RSP;
        w_src_b = RSP;
        w_dst_e = RSP;
        w_dst_m = rA;
      end
      default: ; // halt, nop, jXX and invalid codes touch no registers
    endcase
  end

  assign srcA = w_src_a;
  assign srcB = w_src_b;
  assign dstE = w_dst_e;
  assign dstM = w_dst_m;

  // ---------------------------------------------------------------------------
  // Reads: there is no write bypass. SEQ commits at the end of the
  // instruction, so the current instruction must see pre-write values.
  // ---------------------------------------------------------------------------
  assign valA    = (w_src_a == RNONE) ? '0 : r_regs[w_src_a];
  assign valB    = (w_src_b == RNONE) ? '0 : r_regs[w_src_b];
  assign dbg_val = (dbg_sel == RNONE) ? '0 : r_regs[dbg_sel];

  // ---------------------------------------------------------------------------
  // Write-back
  // ---------------------------------------------------------------------------
  // NOTE: the register array is reset explicitly. %rsp must come out of reset
  // holding RSP_INIT, and a program may read any register before writing it.
  // NOTE: sequential state uses non-blocking assignments so that every register
  // samples pre-edge values, whatever order the loop visits them in.
  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= (i == int'(RSP)) ? RSP_INIT : '0;
      end
    end else if (wr_en) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        // dstM has priority, so popq %rsp keeps the popped value.
        if (w_dst_m == 4'(i)) begin
          r_regs[i] <= valM;
        end else if (w_dst_e == 4'(i)) begin
          r_regs[i] <= valE;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_regfile.sv
// ---------------------------------------------------------------------------
// tb_seq_regfile
//   Directed bench for seq_regfile with RSP_INIT = 64'h200. Inputs change on
//   the falling clock edge. Outputs are sampled 1 time unit after a rising
//   edge, or away from any edge.
// ---------------------------------------------------------------------------
module tb_seq_regfile;

  localparam int unsigned N = 64;
  localparam logic [3:0]  F = 4'hF;

  logic         clk;
  logic         async_reset;
  logic         wr_en;
  logic [3:0]   icode;
  logic [3:0]   rA;
  logic [3:0]   rB;
  logic         cnd;
  logic [N-1:0] valE;
  logic [N-1:0] valM;
  logic [3:0]   dbg_sel;
  logic [N-1:0] valA;
  logic [N-1:0] valB;
  logic [3:0]   srcA;
  logic [3:0]   srcB;
  logic [3:0]   dstE;
  logic [3:0]   dstM;
  logic [N-1:0] dbg_val;

  int n_checks = 0;
  int n_fail   = 0;

  seq_regfile #(
    .N        (N),
    .RSP_INIT (64'h200)
  ) dut (
    .clk         (clk),
    .async_reset (async_reset),
    .wr_en       (wr_en),
    .icode       (icode),
    .rA          (rA),
    .rB          (rB),
    .cnd         (cnd),
    .valE        (valE),
    .valM        (valM),
    .dbg_sel     (dbg_sel),
    .valA        (valA),
    .valB        (valB),
    .srcA        (srcA),
    .srcB        (srcB),
    .dstE        (dstE),
    .dstM        (dstM),
    .dbg_val     (dbg_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input string tag, input logic [3:0] sel, input logic [N-1:0] exp);
    dbg_sel = sel;
    #1;
    check(tag, dbg_val, exp);
  endtask

  task automatic check_ids(input string tag, input logic [3:0] sa, input logic [3:0] sb,
                           input logic [3:0] de, input logic [3:0] dm);
    #1;
    check({tag, ".srcA"}, 64'(srcA), 64'(sa));
    check({tag, ".srcB"}, 64'(srcB), 64'(sb));
    check({tag, ".dstE"}, 64'(dstE), 64'(de));
    check({tag, ".dstM"}, 64'(dstM), 64'(dm));
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    async_reset = 1'b1;
    wr_en   = 1'b0;
    icode   = 4'h0;
    rA      = F;
    rB      = F;
    cnd     = 1'b0;
    valE    = '0;
    valM    = '0;
    dbg_sel = 4'h4;

    // ---- Reset values: assert mid-cycle, no clock edge needed ----
    #7;
    async_reset = 1'b0;
    #1;
    check("reset_r4_immediate", dbg_val, 64'h200);
    for (int i = 0; i < 15; i++) begin
      if (i != 4) check_reg($sformatf("reset_r%0d", i), 4'(i), 64'h0);
    end
    check_reg("reset_rnone", F, 64'h0);
    @(negedge clk);
    async_reset = 1'b1;

    // ---- irmovq $0x1234, %rdx ----
    @(negedge clk);
    icode = 4'h3; rA = F; rB = 4'h2; valE = 64'h1234; wr_en = 1'b1;
    check_ids("irmovq_ids", F, F, 4'h2, F);
    edge_step();
    check_reg("irmovq_r2", 4'h2, 64'h1234);

    // ---- OPq reads the value back on both ports ----
    @(negedge clk);
    wr_en = 1'b0; icode = 4'h6; rA = 4'h2; rB = 4'h2;
    check_ids("opq_ids", 4'h2, 4'h2, 4'h2, F);
    check("opq_valA", valA, 64'h1234);
    check("opq_valB", valB, 64'h1234);

    // ---- cmovXX, condition false then true ----
    @(negedge clk);
    icode = 4'h2; rA = 4'h1; rB = 4'h3; valE = 64'h55; cnd = 1'b0; wr_en = 1'b1;
    check_ids("cmov_nc_ids", 4'h1, F, F, F);
    edge_step();
    check_reg("cmov_nc_r3", 4'h3, 64'h0);
    @(negedge clk);
    cnd = 1'b1;
    #1;
    check("cmov_c_dstE", 64'(dstE), 64'h3);
    edge_step();
    check_reg("cmov_c_r3", 4'h3, 64'h55);

    // ---- popq %rsp: valM wins over valE ----
    @(negedge clk);
    cnd = 1'b0; icode = 4'h3; rA = F; rB = 4'h4; valE = 64'h100;
    edge_step();
    check_reg("rsp_set", 4'h4, 64'h100);
    @(negedge clk);
    icode = 4'hB; rA = 4'h4; rB = F; valE = 64'h108; valM = 64'hABCD;
    check_ids("popq_rsp_ids", 4'h4, 4'h4, 4'h4, 4'h4);
    check("popq_rsp_valA_pre", valA, 64'h100);
    edge_step();
    check_reg("popq_rsp_r4", 4'h4, 64'hABCD);

    // ---- mrmovq 0(%rdx), %rsi ----
    @(negedge clk);
    icode = 4'h5; rA = 4'h6; rB = 4'h2; valE = 64'h1234; valM = 64'hBEEF;
    check_ids("mrmovq_ids", F, 4'h2, F, 4'h6);
    check("mrmovq_valB", valB, 64'h1234);
    edge_step();
    check_reg("mrmovq_r6", 4'h6, 64'hBEEF);

    // ---- Other decodes ----
    @(negedge clk);
    wr_en = 1'b0;
    icode = 4'hA; rA = 4'h3; rB = F;
    check_ids("pushq_ids", 4'h3, 4'h4, 4'h4, F);
    icode = 4'h8;
    check_ids("call_ids", F, 4'h4, 4'h4, F);
    icode = 4'h9;
    check_ids("ret_ids", 4'h4, 4'h4, 4'h4, F);
    icode = 4'h4; rA = 4'h3; rB = 4'h6;
    check_ids("rmmovq_ids", 4'h3, 4'h6, F, F);
    icode = 4'h7;
    check_ids("jxx_ids", F, F, F, F);
    icode = 4'hC;
    check_ids("invalid_ids", F, F, F, F);

    // ---- Stall: wr_en=0 blocks the write ----
    icode = 4'h3; rA = F; rB = 4'h5; valE = 64'h77; wr_en = 1'b0;
    edge_step();
    check_reg("stall_r5", 4'h5, 64'h0);

    // ---- Write to RNONE changes nothing ----
    @(negedge clk);
    icode = 4'h3; rA = F; rB = F; valE = 64'hDEAD; wr_en = 1'b1;
    #1;
    check("rnone_dstE", 64'(dstE), 64'(F));
    check("rnone_valA", valA, 64'h0);
    edge_step();
    check_reg("rnone_r0", 4'h0, 64'h0);
    check_reg("rnone_r2", 4'h2, 64'h1234);
    check_reg("rnone_r3", 4'h3, 64'h55);
    check_reg("rnone_r4", 4'h4, 64'hABCD);
    check_reg("rnone_r5", 4'h5, 64'h0);
    check_reg("rnone_r6", 4'h6, 64'hBEEF);
    check_reg("rnone_r14", 4'hE, 64'h0);

    // ---- halt ----
    @(negedge clk);
    wr_en = 1'b0; icode = 4'h0; rA = 4'h1; rB = 4'h2;
    check_ids("halt_ids", F, F, F, F);

    // ---- Reset in the middle of operation ----
    @(negedge clk);
    icode = 4'h3; rA = F; rB = 4'h7; valE = 64'h9; wr_en = 1'b1;
    edge_step();
    check_reg("midrst_r7_written", 4'h7, 64'h9);
    valE = 64'hFF;                 // pending write, never lands during reset
    #1;
    async_reset = 1'b0;
    #1;
    check_reg("midrst_r7_cleared", 4'h7, 64'h0);
    check_reg("midrst_r4_init", 4'h4, 64'h200);
    edge_step();                   // edge while reset is held
    check_reg("midrst_r7_held", 4'h7, 64'h0);
    @(negedge clk);
    async_reset = 1'b1;
    #1;
    check_reg("midrst_r7_released", 4'h7, 64'h0);
    edge_step();
    check_reg("midrst_r7_after", 4'h7, 64'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Backstop so the run always ends.
  initial begin
    #20000;
    $display("FAIL timeout: observed still running expected finished");
    $fatal(1, "timeout");
  end

endmodule
